// File: rtl/vga_block_pkg.sv
// Shared types and constants for the block-based VGA frame-buffer fill path.
//   fill_state_t     : sequencer FSM states
//   DEFAULT_BLOCKS_X : blocks per row (640 px / 16 px)
//   DEFAULT_BLOCKS_Y : blocks per column (480 px / 16 px)
//   BLOCK_PIXELS     : pixels per block edge
//   COORD_W          : width of the block coordinate buses
package vga_block_pkg;

  localparam int unsigned DEFAULT_BLOCKS_X = 40;
  localparam int unsigned DEFAULT_BLOCKS_Y = 30;
  localparam int unsigned BLOCK_PIXELS     = 16;
  localparam int unsigned COORD_W          = 10;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrain,
    StWaitSwap
  } fill_state_t;

endpackage

// File: rtl/block_coord_counter.sv
// Block coordinate walker: raster-order x/y plus a running linear address,
// so the RAM address never needs a multiplier.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   advance      : step to the next block (wraps to 0,0 after the last block)
//   clear        : force x, y and address to 0 (wins over advance)
//   x, y         : current block coordinates
//   addr         : y*BLOCKS_X + x, maintained incrementally
//   last         : current block is (BLOCKS_X-1, BLOCKS_Y-1)
module block_coord_counter
  import vga_block_pkg::*;
#(
  parameter int unsigned BLOCKS_X = DEFAULT_BLOCKS_X,
  parameter int unsigned BLOCKS_Y = DEFAULT_BLOCKS_Y,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               advance,
  input  logic               clear,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  localparam logic [COORD_W-1:0] XMax = COORD_W'(BLOCKS_X - 1);
  localparam logic [COORD_W-1:0] YMax = COORD_W'(BLOCKS_Y - 1);

  logic [COORD_W-1:0] xQ, xD, yQ, yD;
  logic [ADDR_W-1:0]  addrQ, addrD;

  assign last = (xQ == XMax) && (yQ == YMax);

  always_comb begin
    xD    = xQ;
    yD    = yQ;
    addrD = addrQ;
    if (clear) begin
      xD    = '0;
      yD    = '0;
      addrD = '0;
    end else if (advance) begin
      if (last) begin
        xD    = '0;
        yD    = '0;
        addrD = '0;
      end else begin
        addrD = addrQ + ADDR_W'(1);
        if (xQ == XMax) begin
          xD = '0;
          yD = yQ + COORD_W'(1);
        end else begin
          xD = xQ + COORD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      xQ    <= '0;
      yQ    <= '0;
      addrQ <= '0;
    end else begin
      xQ    <= xD;
      yQ    <= yD;
      addrQ <= addrD;
    end
  end

  assign x    = xQ;
  assign y    = yQ;
  assign addr = addrQ;

endmodule

// File: rtl/block_fill_sequencer.sv
// Walks every block coordinate once per frame, captures the graphics
// controller's pixelPacking for it and writes it into the back buffer of a
// double-buffered block RAM. Buffers swap on the first frame_start after a
// completed fill.
// Ports:
//   clk, reset_n             : clock, synchronous active-low reset
//   frame_start              : one-cycle pulse at start of vertical blanking
//   x/y_coord_of_current_block : coordinates presented to the controller
//   whichRAM                 : back buffer being filled (also controller pattern)
//   pixelPacking             : controller result for the current coordinates
//   wr_en/wr_addr/wr_data    : RAM write request, held until wr_ready
//   wr_ready                 : RAM accepts the pending write this edge
//   display_sel              : front buffer, always ~whichRAM
//   busy                     : fill or drain in progress
//   done                     : pulse when the final write of a fill is accepted
//   overrun                  : pulse when frame_start arrives while busy
module block_fill_sequencer
  import vga_block_pkg::*;
#(
  parameter int unsigned BLOCKS_X = DEFAULT_BLOCKS_X,
  parameter int unsigned BLOCKS_Y = DEFAULT_BLOCKS_Y,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  output logic [COORD_W-1:0] x_coord_of_current_block,
  output logic [COORD_W-1:0] y_coord_of_current_block,
  output logic               whichRAM,
  input  logic [7:0]         pixelPacking,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_data,
  input  logic               wr_ready,
  output logic               display_sel,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  fill_state_t       stateQ, stateD;
  logic              whichRamQ, whichRamD;
  logic              wrEnQ, wrEnD;
  logic [ADDR_W-1:0] wrAddrQ, wrAddrD;
  logic [7:0]        wrDataQ, wrDataD;
  logic              doneQ, doneD;
  logic              overrunQ, overrunD;

  logic              advance, clear, last, slotFree;
  logic [ADDR_W-1:0] curAddr;

  block_coord_counter #(
    .BLOCKS_X (BLOCKS_X),
    .BLOCKS_Y (BLOCKS_Y),
    .ADDR_W   (ADDR_W)
  ) uCoord (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (advance),
    .clear   (clear),
    .x       (x_coord_of_current_block),
    .y       (y_coord_of_current_block),
    .addr    (curAddr),
    .last    (last)
  );

  // A new capture may overwrite the write register only once it is empty or
  // being accepted on this same edge.
  assign slotFree = !wrEnQ || wr_ready;

  always_comb begin
    stateD    = stateQ;
    whichRamD = whichRamQ;
    wrEnD     = wrEnQ;
    wrAddrD   = wrAddrQ;
    wrDataD   = wrDataQ;
    doneD     = 1'b0;
    overrunD  = 1'b0;
    advance   = 1'b0;
    clear     = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (frame_start) begin
          stateD = StFill;
          clear  = 1'b1;
        end
      end
      StFill: begin
        overrunD = frame_start;
        if (slotFree) begin
          wrEnD   = 1'b1;
          wrAddrD = curAddr;
          wrDataD = pixelPacking;
          advance = 1'b1;  // counter wraps itself to 0,0 after the last block
          if (last) stateD = StDrain;
        end
      end
      StDrain: begin
        overrunD = frame_start;
        if (wr_ready) begin
          wrEnD  = 1'b0;
          doneD  = 1'b1;
          stateD = StWaitSwap;
        end
      end
      StWaitSwap: begin
        if (frame_start) begin
          whichRamD = ~whichRamQ;
          stateD    = StFill;
          clear     = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stateQ    <= StIdle;
      whichRamQ <= 1'b0;
      wrEnQ     <= 1'b0;
      wrAddrQ   <= '0;
      wrDataQ   <= '0;
      doneQ     <= 1'b0;
      overrunQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      whichRamQ <= whichRamD;
      wrEnQ     <= wrEnD;
      wrAddrQ   <= wrAddrD;
      wrDataQ   <= wrDataD;
      doneQ     <= doneD;
      overrunQ  <= overrunD;
    end
  end

  assign whichRAM    = whichRamQ;
  assign display_sel = ~whichRamQ;
  assign wr_en       = wrEnQ;
  assign wr_addr     = wrAddrQ;
  assign wr_data     = wrDataQ;
  assign busy        = (stateQ == StFill) || (stateQ == StDrain);
  assign done        = doneQ;
  assign overrun     = overrunQ;

endmodule

// File: tb/tb_block_fill_sequencer.sv
module tb_block_fill_sequencer;

  localparam int BX = 40;
  localparam int BY = 30;
  localparam int NB = BX * BY;

  logic        clk = 1'b0;
  logic        reset_n, frame_start, wr_ready;
  logic [9:0]  xc, yc;
  logic        whichRAM;
  logic [7:0]  pixelPacking;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        display_sel, busy, done, overrun;

  always #5 clk = ~clk;

  block_fill_sequencer dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .frame_start              (frame_start),
    .x_coord_of_current_block (xc),
    .y_coord_of_current_block (yc),
    .whichRAM                 (whichRAM),
    .pixelPacking             (pixelPacking),
    .wr_en                    (wr_en),
    .wr_addr                  (wr_addr),
    .wr_data                  (wr_data),
    .wr_ready                 (wr_ready),
    .display_sel              (display_sel),
    .busy                     (busy),
    .done                     (done),
    .overrun                  (overrun)
  );

  // Controller stand-in: one random pattern per buffer, looked up by block.
  logic [7:0] pat [0:1][0:NB-1];

  always_comb begin
    pixelPacking = 8'h00;
    if (int'(xc) < BX && int'(yc) < BY) pixelPacking = pat[whichRAM][int'(yc) * BX + int'(xc)];
  end

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t expQ[$];
  int  checks = 0, failures = 0, cyc = 0, ovCount = 0, doneCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a write transfers on the next edge if wr_en && wr_ready now.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n === 1'b1) begin
      if (overrun === 1'b1) ovCount++;
      if (done === 1'b1) doneCount++;
    end
    if (wr_en === 1'b1 && wr_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d expected no write", wr_addr);
      end else begin
        e = expQ.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: a fill writes every linear address once, in order.
  task automatic pushFill(input int b);
    for (int a = 0; a < NB; a++) expQ.push_back(wr_t'{addr: 11'(a), data: pat[b][a]});
  endtask

  task automatic startFrame(input int b, output int c0);
    frame_start = 1'b1;
    pushFill(b);
    step();
    frame_start = 1'b0;
    c0 = cyc;
  endtask

  task automatic waitAddr(input int a, input int limit);
    int n = 0;
    while (!(wr_en === 1'b1 && int'(wr_addr) == a) && n < limit) begin
      step();
      n++;
    end
    check("wait_addr_reached", 32'(wr_en === 1'b1 && int'(wr_addr) == a), 32'd1);
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    check("wait_done_seen", 32'(done === 1'b1), 32'd1);
  endtask

  initial begin
    int c0;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    wr_ready    = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < NB; a++) pat[b][a] = 8'($urandom);
    pat[0][0]   = 8'h10;
    pat[0][520] = 8'h38;
    pat[1][0]   = 8'h07;
    pat[1][1]   = 8'h00;
    pat[1][41]  = 8'h07;
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_whichRAM", 32'(whichRAM), 0);
    check("rst_display_sel", 32'(display_sel), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_x", 32'(xc), 0);
    check("rst_y", 32'(yc), 0);

    // Fill 1: buffer 0, no stalls
    startFrame(0, c0);
    check("f1_busy", 32'(busy), 1);
    check("f1_whichRAM_start", 32'(whichRAM), 0);
    waitDone(3000);
    check("f1_done_latency", 32'(cyc - c0), 32'(NB + 1));
    check("f1_whichRAM_end", 32'(whichRAM), 0);
    check("f1_queue_empty", 32'(expQ.size()), 0);
    step();
    check("f1_done_pulse", 32'(done), 0);
    check("f1_idle_busy", 32'(busy), 0);

    // Fill 2: swap to buffer 1, stall at 100, overrun at 600
    startFrame(1, c0);
    check("f2_whichRAM", 32'(whichRAM), 1);
    check("f2_display_sel", 32'(display_sel), 0);
    waitAddr(100, 3000);
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_wr_en", 32'(wr_en), 1);
      check("stall_wr_addr", 32'(wr_addr), 100);
      check("stall_wr_data", 32'(wr_data), 32'(pat[1][100]));
    end
    wr_ready = 1'b1;
    waitAddr(600, 3000);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("ovr_pulse_high", 32'(overrun), 1);
    step();
    check("ovr_pulse_low", 32'(overrun), 0);
    waitDone(3000);
    check("f2_done_latency", 32'(cyc - c0), 32'(NB + 1 + 5));
    check("f2_whichRAM_end", 32'(whichRAM), 1);
    check("f2_queue_empty", 32'(expQ.size()), 0);
    check("f2_overrun_count", 32'(ovCount), 1);

    // Fill 3: buffer 0, frame_start on the drain-completion edge
    startFrame(0, c0);
    check("f3_whichRAM", 32'(whichRAM), 0);
    check("f3_display_sel", 32'(display_sel), 1);
    while (cyc < c0 + NB) step();
    check("f3_draining", 32'(busy), 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("f3_done", 32'(done), 1);
    check("f3_overrun", 32'(overrun), 1);
    check("f3_busy", 32'(busy), 0);
    repeat (3) step();
    check("f3_no_swap", 32'(whichRAM), 0);
    check("f3_wait_busy", 32'(busy), 0);
    check("f3_done_count", 32'(doneCount), 3);
    check("f3_overrun_count", 32'(ovCount), 2);
    check("f3_queue_empty", 32'(expQ.size()), 0);

    // Fill 4: swap to buffer 1, reset at address 300
    startFrame(1, c0);
    check("f4_whichRAM", 32'(whichRAM), 1);
    waitAddr(300, 3000);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    expQ.delete();
    check("mrst_wr_en", 32'(wr_en), 0);
    check("mrst_whichRAM", 32'(whichRAM), 0);
    check("mrst_display_sel", 32'(display_sel), 1);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_x", 32'(xc), 0);
    check("mrst_y", 32'(yc), 0);
    repeat (2) step();
    check("mrst_idle_wr_en", 32'(wr_en), 0);

    // Fill 5: from IDLE, so no swap
    startFrame(0, c0);
    check("f5_whichRAM", 32'(whichRAM), 0);
    waitDone(3000);
    check("f5_done_latency", 32'(cyc - c0), 32'(NB + 1));
    check("f5_queue_empty", 32'(expQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
